// File: rtl/mmio_timer_if.sv
// MEM-stage data-bus view of the memory-mapped timer: the core drives the store strobe, address
// and data, and the timer returns read data plus the window hit flag.
interface mmio_timer_if;
   logic        memwrite;
   logic [31:0] memaddr;
   logic [31:0] memwritedata;
   logic [31:0] memreaddata;
   logic        sel;

   modport master (output memwrite, memaddr, memwritedata, input memreaddata, sel);
   modport slave  (input memwrite, memaddr, memwritedata, output memreaddata, sel);
endinterface

// File: rtl/mmio_timer.sv
// Memory-mapped down-counting timer (CTRL/LOAD/COUNT/STAT) with prescaler, one-shot/periodic expiry.
// Optional feature macro TIMER_IRQ_EN: implements CTRL.IE and the registered irq line.
module mmio_timer #(
   parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
   parameter int          PRESCALE  = 1
) (
   input  logic        clk,
   input  logic        reset,
   mmio_timer_if.slave bus,
   output logic        irq
);
   localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

   logic        en_reg, en_next;
   logic        periodic_reg, periodic_next;
   logic        ie_reg, ie_next;
   logic        exp_reg, exp_next;
   logic        irq_reg, irq_next;
   logic [31:0] load_reg, load_next;
   logic [31:0] count_reg, count_next;
   logic [15:0] pre_reg, pre_next;
   logic        tick, expire;
   logic        wr_ctrl, wr_load, wr_stat;
   logic        unused_addr_bits;

   assign unused_addr_bits = ^bus.memaddr[1:0];

   assign bus.sel = (bus.memaddr[31:4] == BASE_ADDR[31:4]);
   assign wr_ctrl = bus.memwrite & bus.sel & (bus.memaddr[3:2] == 2'd0);
   assign wr_load = bus.memwrite & bus.sel & (bus.memaddr[3:2] == 2'd1);
   assign wr_stat = bus.memwrite & bus.sel & (bus.memaddr[3:2] == 2'd3);

   assign tick   = en_reg & (pre_reg == PRE_LAST);
   // A LOAD write on a tick edge pre-empts both the decrement and any expiry.
   assign expire = tick & ~wr_load & (count_reg == 32'd0);

   always_comb begin
      bus.memreaddata = 32'h0;
      if (bus.sel) begin
         case (bus.memaddr[3:2])
            2'd0:    bus.memreaddata = {29'd0, ie_reg, periodic_reg, en_reg};
            2'd1:    bus.memreaddata = load_reg;
            2'd2:    bus.memreaddata = count_reg;
            default: bus.memreaddata = {31'd0, exp_reg};
         endcase
      end
   end

   always_comb begin
      load_next     = load_reg;
      count_next    = count_reg;
      en_next       = en_reg;
      periodic_next = periodic_reg;
      ie_next       = ie_reg;
      exp_next      = exp_reg;
      pre_next      = pre_reg;

      if (wr_load) begin
         load_next  = bus.memwritedata;
         count_next = bus.memwritedata;
      end else if (tick) begin
         if (count_reg != 32'd0)
            count_next = count_reg - 32'd1;
         else if (periodic_reg)
            count_next = load_reg;
      end

      // Expiry decisions use the pre-write CTRL; a one-shot expiry overrides a written EN=1.
      if (wr_ctrl) begin
         en_next       = bus.memwritedata[0];
         periodic_next = bus.memwritedata[1];
`ifdef TIMER_IRQ_EN
         ie_next       = bus.memwritedata[2];
`endif
      end
`ifndef TIMER_IRQ_EN
      ie_next = 1'b0;
`endif
      if (expire && !periodic_reg)
         en_next = 1'b0;

      if (wr_stat && bus.memwritedata[0])
         exp_next = 1'b0;
      if (expire)
         exp_next = 1'b1;

      // Prescaler restarts from zero when disabled, when enabled afresh, and after every tick.
      if (!en_next || !en_reg || tick)
         pre_next = 16'd0;
      else
         pre_next = pre_reg + 16'd1;

      irq_next = exp_next & ie_next;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         en_reg       <= 1'b0;
         periodic_reg <= 1'b0;
         ie_reg       <= 1'b0;
         exp_reg      <= 1'b0;
         irq_reg      <= 1'b0;
         load_reg     <= 32'd0;
         count_reg    <= 32'd0;
         pre_reg      <= 16'd0;
      end else begin
         en_reg       <= en_next;
         periodic_reg <= periodic_next;
         ie_reg       <= ie_next;
         exp_reg      <= exp_next;
         irq_reg      <= irq_next;
         load_reg     <= load_next;
         count_reg    <= count_next;
         pre_reg      <= pre_next;
      end
   end

   assign irq = irq_reg;
endmodule
